monkey_motion_ctrl: RTL and testbench
=====================================

// Module: monkey_motion_ctrl
// PURPOSE
// - Frame-rate FSM that sequences the monkey sprite's motion datapath: GROUND / JUMP / FALL / CLIMB / DEAD.
// - Converts raw keypad levels into the qualified command levels jump/move_up/move_down/move_left/move_right.
// - Commands feed the monkey position/collision datapath; collision flags come back from the collision matrix.
// - Sits between keypad decoder and monkey position block; also reports death/respawn to game controller.
// PARAMETERS
// - JUMP_FRAMES   default 8   frames jump held asserted after a jump is accepted
// - DEATH_FRAMES  default 60  frames spent in DEAD before respawn pulse
// - COYOTE_FRAMES default 4   late-jump window in frames (used only with COYOTE_JUMP_EN)
// PORTS
// - clk           in   1  system clock
// - resetN        in   1  asynchronous, active-low reset
// - startOfFrame  in   1  one-cycle pulse per video frame; all state transitions qualify on it
// - key_up/key_down/key_left/key_right/key_jump  in 1 each  raw keypad levels, asynchronous
// - on_ground     in   1  monkey bottom edge touching platform (level, clk domain)
// - on_rope       in   1  monkey overlaps rope (level, clk domain)
// - hit_enemy     in   1  monkey collided with enemy/fruit-hazard (level, clk domain)
// - jump, move_up, move_down, move_left, move_right  out 1 each  registered commands to position block
// - state         out  3  current FSM state encoding (monkey_pkg::motion_state_t)
// - facing_left   out  1  last horizontal direction, 1 = left; selects mirrored bitmap
// - dead          out  1  high while in DEAD
// - respawn       out  1  one-cycle pulse when leaving DEAD
// BEHAVIOUR
// - Reset: state=FALL; all command outputs 0; facing_left=0; dead=0; respawn=0; counters 0; jump_req=0.
// - Keys pass 2-flop synchronisers; key_jump rising edge (sync'd) sets sticky jump_req, cleared at next startOfFrame.
// - Transitions evaluated only on startOfFrame cycles, except hit_enemy: any cycle, any state except DEAD -> DEAD next clk.
// - GROUND: jump_req -> JUMP (jcnt=JUMP_FRAMES-1); else on_rope & key_up -> CLIMB; else !on_ground -> FALL.
// - JUMP: decrement jcnt each frame; jcnt==0 -> FALL. on_rope & key_up at frame -> CLIMB (grab mid-air).
// - FALL: on_ground -> GROUND; else on_rope & (key_up|key_down) -> CLIMB.
// - CLIMB: jump_req -> FALL (let go); !on_rope -> FALL; on_ground & key_down -> GROUND.
// - DEAD: dcnt counts DEATH_FRAMES frames; at terminal count -> FALL, respawn=1 for one clk; hit_enemy ignored.
// - Priority on same frame: hit_enemy > jump_req > rope grab > ground/fall checks.
// - Commands (registered, one clk after state): jump=1 only in JUMP; move_up/down=sync key only in CLIMB;
//   move_left/right=sync key in GROUND/JUMP/FALL, 0 in CLIMB/DEAD; left&right both pressed -> both 0.
// - facing_left updates only when exactly one of left/right is asserted and state != DEAD.
// - Counters saturate-safe: jcnt/dcnt width $clog2(param+1); no wrap; reset mid-jump/death returns to FALL.
// - Output latency: key edge to command change <= 1 frame + 3 clk.
// CONFIGURATION
// - COYOTE_JUMP_EN defined: entering FALL from GROUND loads ccnt=COYOTE_FRAMES; while ccnt>0 in FALL,
//   jump_req -> JUMP; ccnt decrements per frame. Falling from JUMP/CLIMB loads 0.
// - COYOTE_JUMP_EN undefined: jump_req ignored in FALL; ccnt logic absent; COYOTE_FRAMES unused.
// STRUCTURE
// - monkey_pkg: typedef enum logic [2:0] motion_state_t {GROUND, JUMP, FALL, CLIMB, DEAD}; shared with
//   sprite selector and score/lives controller; also holds FRAME_RATE=30 constant.
// - Sub-module key_sync_edge (2-flop sync + rising-edge detect, one instance per key, 5 total).
// - Top: FSM, frame counters, command register stage.
// TESTING
// - Reset then on_ground=1, one frame -> state GROUND, all commands 0, facing_left=0.
// - GROUND, key_jump pulse 2 clk mid-frame -> JUMP at next SOF, jump=1 for exactly 8 frames, then FALL.
// - FALL, on_rope=1, key_up held -> CLIMB; move_up=1, move_left=0 despite key_left=1.
// - CLIMB, key_jump edge -> FALL next frame; on_ground=1 next frame -> GROUND.
// - hit_enemy mid-frame in JUMP -> DEAD next clk, dead=1; after 60 frames respawn 1-clk pulse, state FALL.
// - COYOTE_JUMP_EN: walk off ledge, jump at frame 3 of FALL -> JUMP; at frame 5 -> stays FALL.

Source files
------------

// File: rtl/monkey_pkg.sv
// Shared definitions for the monkey sprite motion logic.
// - motion_state_t: motion FSM state encoding, also decoded by the sprite selector and the
//   score/lives controller, so the encoding order is fixed.
// - FRAME_RATE: video frames per second.
// - KEY_*: bit positions of the keypad lines inside the packed key vectors of the top level.
package monkey_pkg;

  typedef enum logic [2:0] {
    GROUND = 3'd0,
    JUMP   = 3'd1,
    FALL   = 3'd2,
    CLIMB  = 3'd3,
    DEAD   = 3'd4
  } motion_state_t;

  localparam int unsigned FRAME_RATE = 30;

  localparam int unsigned NUM_KEYS  = 5;
  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned KEY_JUMP  = 4;

  // States in which the monkey may be steered left/right.
  function automatic logic steers_horizontally(motion_state_t s);
    return (s == GROUND) || (s == JUMP) || (s == FALL);
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw keypad line.
// Ports:
// - clk    in  system clock
// - resetN in  asynchronous active-low reset
// - key    in  raw asynchronous key level
// - level  out synchronised key level (2 clk latency)
// - rise   out one-clk pulse on a 0->1 transition of level
module key_sync_edge (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic level,
  output logic rise
);

  // [0],[1] form the synchroniser; [2] is the previous synchronised value for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], key};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/monkey_motion_ctrl.sv
// Frame-rate motion FSM for the monkey sprite (GROUND / JUMP / FALL / CLIMB / DEAD).
// Turns raw keypad levels into registered motion commands for the position block and reports
// death/respawn to the game controller. State changes happen on startOfFrame cycles only,
// except an enemy hit, which enters DEAD on the next clock from any live state.
// Ports:
// - clk, resetN                      clock, asynchronous active-low reset
// - startOfFrame                     one-clk pulse per video frame
// - key_up/down/left/right/jump      raw asynchronous keypad levels
// - on_ground, on_rope, hit_enemy    collision flags (clk domain levels)
// - jump, move_up/down/left/right    registered commands, one clk behind state
// - state                            current motion_state_t encoding
// - facing_left                      last single horizontal direction, 1 = left
// - dead                             high while in DEAD
// - respawn                          one-clk pulse when leaving DEAD
// Build option: define COYOTE_JUMP_EN to accept a late jump for COYOTE_FRAMES frames after
// walking off a ledge; otherwise jump requests are ignored in FALL.
module monkey_motion_ctrl
  import monkey_pkg::*;
#(
  parameter int unsigned JUMP_FRAMES   = 8,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned COYOTE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       on_ground,
  input  logic       on_rope,
  input  logic       hit_enemy,
  output logic       jump,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [2:0] state,
  output logic       facing_left,
  output logic       dead,
  output logic       respawn
);

  localparam int unsigned JcntW = $clog2(JUMP_FRAMES + 1);
  localparam int unsigned DcntW = $clog2(DEATH_FRAMES + 1);

  // Key synchronisation
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_rise;

  assign key_raw = {key_jump, key_right, key_left, key_down, key_up};

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_sync_edge u_key_sync_edge (
      .clk   (clk),
      .resetN(resetN),
      .key   (key_raw[i]),
      .level (key_level[i]),
      .rise  (key_rise[i])
    );
  end

  logic up_s, down_s, left_s, right_s;
  assign up_s    = key_level[KEY_UP];
  assign down_s  = key_level[KEY_DOWN];
  assign left_s  = key_level[KEY_LEFT];
  assign right_s = key_level[KEY_RIGHT];

  // Only the jump key needs edge detection.
  logic unused_rise;
  assign unused_rise = ^{key_rise[KEY_RIGHT], key_rise[KEY_LEFT], key_rise[KEY_DOWN],
                         key_rise[KEY_UP], key_level[KEY_JUMP]};

  // Sticky jump request: a press anywhere in a frame is seen at the next frame boundary.
  // A press landing on the boundary cycle itself carries over to the following frame.
  logic jump_req_q, jump_req_d;
  assign jump_req_d = key_rise[KEY_JUMP] | (jump_req_q & ~startOfFrame);

  // Motion FSM
  motion_state_t    state_q, state_d;
  logic [JcntW-1:0] jcnt_q, jcnt_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic             respawn_q, respawn_d;
  logic             coyote_jump;

  always_comb begin
    state_d   = state_q;
    jcnt_d    = jcnt_q;
    dcnt_d    = dcnt_q;
    respawn_d = 1'b0;
    if (hit_enemy && (state_q != DEAD)) begin
      state_d = DEAD;
      dcnt_d  = '0;
    end else if (startOfFrame) begin
      unique case (state_q)
        GROUND: begin
          if (jump_req_q) begin
            state_d = JUMP;
            jcnt_d  = JcntW'(JUMP_FRAMES - 1);
          end else if (on_rope && up_s) begin
            state_d = CLIMB;
          end else if (!on_ground) begin
            state_d = FALL;
          end
        end
        JUMP: begin
          if (on_rope && up_s) begin
            state_d = CLIMB;
          end else if (jcnt_q == '0) begin
            state_d = FALL;
          end else begin
            jcnt_d = jcnt_q - JcntW'(1);
          end
        end
        FALL: begin
          if (coyote_jump) begin
            state_d = JUMP;
            jcnt_d  = JcntW'(JUMP_FRAMES - 1);
          end else if (on_rope && (up_s || down_s)) begin
            state_d = CLIMB;
          end else if (on_ground) begin
            state_d = GROUND;
          end
        end
        CLIMB: begin
          if (jump_req_q || !on_rope) begin
            state_d = FALL;
          end else if (on_ground && down_s) begin
            state_d = GROUND;
          end
        end
        DEAD: begin
          if (dcnt_q == DcntW'(DEATH_FRAMES - 1)) begin
            state_d   = FALL;
            dcnt_d    = '0;
            respawn_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DcntW'(1);
          end
        end
        default: state_d = FALL;
      endcase
    end
  end

`ifdef COYOTE_JUMP_EN
  localparam int unsigned CcntW = $clog2(COYOTE_FRAMES + 1);

  // Remaining late-jump frames; armed only when walking off the ground.
  logic [CcntW-1:0] ccnt_q, ccnt_d;

  always_comb begin
    ccnt_d = ccnt_q;
    if ((state_d == FALL) && (state_q == GROUND)) begin
      ccnt_d = CcntW'(COYOTE_FRAMES);
    end else if ((state_d == FALL) && (state_q != FALL)) begin
      ccnt_d = '0;
    end else if ((state_q == FALL) && startOfFrame && (ccnt_q != '0)) begin
      ccnt_d = ccnt_q - CcntW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ccnt_q <= '0;
    end else begin
      ccnt_q <= ccnt_d;
    end
  end

  assign coyote_jump = jump_req_q && (ccnt_q != '0);
`else
  assign coyote_jump = 1'b0;

  logic unused_coyote;
  assign unused_coyote = ^COYOTE_FRAMES;
`endif

  // Command stage, decoded from the current state so commands trail state by one clk.
  logic jump_d, move_up_d, move_down_d, move_left_d, move_right_d, facing_left_d;
  logic steer_ok;

  always_comb begin
    steer_ok      = steers_horizontally(state_q) && !(left_s && right_s);
    jump_d        = (state_q == JUMP);
    move_up_d     = (state_q == CLIMB) && up_s;
    move_down_d   = (state_q == CLIMB) && down_s;
    move_left_d   = steer_ok && left_s;
    move_right_d  = steer_ok && right_s;
    facing_left_d = facing_left;
    if ((state_q != DEAD) && (left_s ^ right_s)) begin
      facing_left_d = left_s;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= FALL;
      jcnt_q      <= '0;
      dcnt_q      <= '0;
      jump_req_q  <= 1'b0;
      respawn_q   <= 1'b0;
      jump        <= 1'b0;
      move_up     <= 1'b0;
      move_down   <= 1'b0;
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      facing_left <= 1'b0;
    end else begin
      state_q     <= state_d;
      jcnt_q      <= jcnt_d;
      dcnt_q      <= dcnt_d;
      jump_req_q  <= jump_req_d;
      respawn_q   <= respawn_d;
      jump        <= jump_d;
      move_up     <= move_up_d;
      move_down   <= move_down_d;
      move_left   <= move_left_d;
      move_right  <= move_right_d;
      facing_left <= facing_left_d;
    end
  end

  assign state   = state_q;
  assign dead    = (state_q == DEAD);
  assign respawn = respawn_q;

endmodule

// File: tb/tb_monkey_motion_ctrl.sv
// Self-checking bench for monkey_motion_ctrl: a frame-level behavioural model predicts every
// output on every clock after reset, plus literal expectations for the directed scenarios.
module tb_monkey_motion_ctrl;

  localparam int JF = 8;
  localparam int DF = 60;
  localparam int CF = 4;
  localparam int FL = 16;  // clocks per video frame

  localparam logic [2:0] S_GROUND = 3'd0;
  localparam logic [2:0] S_JUMP   = 3'd1;
  localparam logic [2:0] S_FALL   = 3'd2;
  localparam logic [2:0] S_CLIMB  = 3'd3;
  localparam logic [2:0] S_DEAD   = 3'd4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic on_ground = 1'b0, on_rope = 1'b0, hit_enemy = 1'b0;
  logic jump, move_up, move_down, move_left, move_right, facing_left, dead, respawn;
  logic [2:0] state;

  monkey_motion_ctrl #(
    .JUMP_FRAMES  (JF),
    .DEATH_FRAMES (DF),
    .COYOTE_FRAMES(CF)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(sof),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_jump    (key_jump),
    .on_ground   (on_ground),
    .on_rope     (on_rope),
    .hit_enemy   (hit_enemy),
    .jump        (jump),
    .move_up     (move_up),
    .move_down   (move_down),
    .move_left   (move_left),
    .move_right  (move_right),
    .state       (state),
    .facing_left (facing_left),
    .dead        (dead),
    .respawn     (respawn)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: keys reach the FSM two clocks after sampling; vectors are {jump,right,left,down,up}.
  logic [4:0] k1 = '0, k2 = '0, k3 = '0;
  logic [2:0] m_state = S_FALL;
  bit m_jreq = 0;
  int m_jump_frames = 0, m_dead_frames = 0, m_fall_frames = CF;
  bit e_jump = 0, e_up = 0, e_down = 0, e_left = 0, e_right = 0, e_facing = 0, e_respawn = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic model_step();
    logic [4:0] sy;
    logic [2:0] cur;
    bit jr, rise, steer;
    sy    = k2;
    cur   = m_state;
    jr    = m_jreq;
    rise  = k2[4] && !k3[4];
    steer = (cur == S_GROUND || cur == S_JUMP || cur == S_FALL) && !(sy[2] && sy[3]);
    e_jump    = (cur == S_JUMP);
    e_up      = (cur == S_CLIMB) && sy[0];
    e_down    = (cur == S_CLIMB) && sy[1];
    e_left    = steer && sy[2];
    e_right   = steer && sy[3];
    e_respawn = 0;
    if (cur != S_DEAD && sy[2] != sy[3]) e_facing = sy[2];
    if (cur != S_DEAD && hit_enemy) begin
      m_state = S_DEAD;
      m_dead_frames = 0;
    end else if (sof) begin
      case (cur)
        S_GROUND:
          if (jr) begin m_state = S_JUMP; m_jump_frames = 0; end
          else if (on_rope && sy[0]) m_state = S_CLIMB;
          else if (!on_ground) begin m_state = S_FALL; m_fall_frames = 0; end
        S_JUMP: begin
          if (on_rope && sy[0]) m_state = S_CLIMB;
          else begin
            m_jump_frames++;
            if (m_jump_frames == JF) begin m_state = S_FALL; m_fall_frames = CF; end
          end
        end
        S_FALL: begin
`ifdef COYOTE_JUMP_EN
          if (jr && m_fall_frames < CF) begin m_state = S_JUMP; m_jump_frames = 0; end
          else
`endif
          if (on_rope && (sy[0] || sy[1])) m_state = S_CLIMB;
          else if (on_ground) m_state = S_GROUND;
          if (m_fall_frames < CF) m_fall_frames++;
        end
        S_CLIMB:
          if (jr || !on_rope) begin m_state = S_FALL; m_fall_frames = CF; end
          else if (on_ground && sy[1]) m_state = S_GROUND;
        default: begin
          m_dead_frames++;
          if (m_dead_frames == DF) begin
            m_state = S_FALL;
            m_fall_frames = CF;
            e_respawn = 1;
          end
        end
      endcase
    end
    m_jreq = rise || (jr && !sof);
    k3 = k2;
    k2 = k1;
    k1 = {key_jump, key_right, key_left, key_down, key_up};
  endtask

  task automatic compare_all();
    chk("state", state, m_state);
    chk("jump", jump, e_jump);
    chk("move_up", move_up, e_up);
    chk("move_down", move_down, e_down);
    chk("move_left", move_left, e_left);
    chk("move_right", move_right, e_right);
    chk("facing_left", facing_left, e_facing);
    chk("dead", dead, (m_state == S_DEAD));
    chk("respawn", respawn, e_respawn);
  endtask

  // One clock: frame pulse, prediction, edge, then compare on the falling edge.
  task automatic tick();
    sof = (cyc % FL == FL - 1);
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string nm);
    int n;
    n = 0;
    while (state !== tgt && n < budget) begin
      tick();
      n++;
    end
    chk(nm, state, tgt);
  endtask

  task automatic pulse_jump();
    key_jump = 1'b1;
    tick_n(2);
    key_jump = 1'b0;
  endtask

  initial begin
    int jc, rc;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    chk("reset_state", state, S_FALL);
    chk("reset_cmds", {jump, move_up, move_down, move_left, move_right}, 0);
    chk("reset_facing", facing_left, 0);
    chk("reset_dead_respawn", {dead, respawn}, 0);

    // Land on the platform
    on_ground = 1'b1;
    wait_state(S_GROUND, 2 * FL + 4, "reach_ground");
    tick();
    chk("ground_cmds", {jump, move_up, move_down, move_left, move_right}, 0);
    chk("ground_facing", facing_left, 0);

    // Horizontal steering and facing
    key_right = 1'b1;
    tick_n(4);
    chk("walk_right", move_right, 1);
    chk("facing_right", facing_left, 0);
    key_left = 1'b1;
    tick_n(4);
    chk("both_lr_zero", {move_left, move_right}, 0);
    chk("both_lr_facing", facing_left, 0);
    key_right = 1'b0;
    tick_n(4);
    chk("walk_left", move_left, 1);
    chk("facing_left_set", facing_left, 1);
    key_left = 1'b0;
    tick_n(4);

    // Jump lasting exactly JF frames
    while (cyc % FL != 4) tick();
    pulse_jump();
    wait_state(S_JUMP, 2 * FL + 4, "jump_accept");
    on_ground = 1'b0;
    jc = 0;
    for (int i = 0; i < 12 * FL; i++) begin
      tick();
      if (jump === 1'b1) jc++;
      else if (jc > 0) break;
    end
    chk("jump_len_cycles", jc, JF * FL);
    chk("after_jump_fall", state, S_FALL);

    // Jump request while falling after a jump is ignored in both builds
    pulse_jump();
    tick_n(2 * FL);
    chk("fall_ignores_jump", state, S_FALL);

    // Grab a rope while falling
    on_rope = 1'b1;
    key_up = 1'b1;
    key_left = 1'b1;
    wait_state(S_CLIMB, FL + 6, "grab_rope");
    tick_n(3);
    chk("climb_up", move_up, 1);
    chk("climb_no_left", {move_left, move_right}, 0);

    // Let go with a jump, then land
    key_up = 1'b0;
    key_left = 1'b0;
    tick_n(4);
    pulse_jump();
    wait_state(S_FALL, 2 * FL + 6, "let_go");
    on_rope = 1'b0;
    on_ground = 1'b1;
    wait_state(S_GROUND, FL + 6, "land");

    // Enemy hit mid-jump, death and respawn
    pulse_jump();
    wait_state(S_JUMP, 2 * FL + 6, "jump_again");
    tick_n(FL + 3);
    hit_enemy = 1'b1;
    tick();
    hit_enemy = 1'b0;
    chk("hit_dead_state", state, S_DEAD);
    chk("hit_dead_flag", dead, 1);
    tick_n(FL);
    hit_enemy = 1'b1;
    key_right = 1'b1;
    tick_n(4);
    hit_enemy = 1'b0;
    chk("facing_frozen_dead", facing_left, 1);
    chk("dead_no_steer", move_right, 0);
    key_right = 1'b0;
    rc = 0;
    for (int i = 0; i < (DF + 2) * FL; i++) begin
      tick();
      if (respawn === 1'b1) begin
        rc++;
        chk("respawn_state", state, S_FALL);
        break;
      end
    end
    chk("respawn_seen", rc, 1);
    tick();
    chk("respawn_one_clk", respawn, 0);

    // Late jump after walking off a ledge: frame 3 of FALL
    wait_state(S_GROUND, 2 * FL + 4, "respawn_land");
    on_ground = 1'b0;
    wait_state(S_FALL, 2 * FL + 4, "walk_off_1");
    tick_n(2 * FL + 4);
    pulse_jump();
    tick_n(FL);
`ifdef COYOTE_JUMP_EN
    chk("coyote_frame3", state, S_JUMP);
`else
    chk("coyote_frame3", state, S_FALL);
`endif
    on_ground = 1'b1;
    wait_state(S_GROUND, (JF + 4) * FL, "reland");

    // Frame 5 of FALL: too late in either build
    on_ground = 1'b0;
    wait_state(S_FALL, 2 * FL + 4, "walk_off_2");
    tick_n(4 * FL + 4);
    pulse_jump();
    tick_n(FL);
    chk("coyote_frame5", state, S_FALL);
    tick_n(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
